// File: rtl/present80_enc_core_if.sv
// Handshake/data bundle for present80_enc_core.
//   in_valid/in_ready   : plaintext + key request (source -> core)
//   plaintext[63:0]     : block to encrypt
//   key[79:0]           : cipher key
//   out_valid/out_ready : ciphertext response (core -> consumer)
//   ciphertext[63:0]    : registered result
//   busy                : core is running rounds
interface present80_enc_core_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ciphertext;
    logic        busy;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

// File: rtl/present80_enc_core.sv
// Iterative PRESENT-80 encryption: one full round per clock.
//   clk      : sole clock, rising edge
//   rst      : synchronous, active-high reset
//   bus      : slave side of present80_enc_core_if (request, response, busy)
//   ROUNDS   : number of full rounds (1..31), 31 = standard PRESENT-80
// Accept in IDLE -> ROUNDS cycles in RUN -> hold result in DONE until out_ready.
module present80_enc_core #(
    parameter int ROUNDS = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    present80_enc_core_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [4:0] LAST = 5'(ROUNDS);

    logic [1:0]  fsm;
    logic [63:0] state_reg;
    logic [79:0] key_reg;
    logic [4:0]  rc;
    logic [63:0] ct_reg;
    logic        ov;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    // Round datapath: addRoundKey -> S-layer -> P-layer
    logic [63:0] t, s, p;
    assign t = state_reg ^ key_reg[79:16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sbox
            assign s[4*gi +: 4] = sbox(t[4*gi +: 4]);
        end
        // bit j moves to 16*j mod 63; bit 63 is a fixed point
        for (gi = 0; gi < 63; gi++) begin : g_perm
            assign p[(16*gi) % 63] = s[gi];
        end
    endgenerate
    assign p[63] = s[63];

    // Key schedule runs alongside the round, from the pre-round key
    logic [79:0] krot, knext;
    always_comb begin
        krot          = {key_reg[18:0], key_reg[79:19]};
        knext         = krot;
        knext[79:76]  = sbox(krot[79:76]);
        knext[19:15]  = krot[19:15] ^ rc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rc        <= '0;
            ct_reg    <= '0;
            ov        <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        fsm       <= RUN;
                        state_reg <= bus.plaintext;
                        key_reg   <= bus.key;
                        rc        <= 5'd1;
                    end
                end
                RUN: begin
                    state_reg <= p;
                    key_reg   <= knext;
                    rc        <= rc + 5'd1;
                    if (rc == LAST) begin
                        // final whitening uses the key produced this same cycle
                        fsm    <= DONE;
                        ov     <= 1'b1;
                        ct_reg <= p ^ knext[79:16];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm <= IDLE;
                        ov  <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (fsm == IDLE) && !rst;
    assign bus.out_valid  = ov;
    assign bus.ciphertext = ct_reg;
    assign bus.busy       = (fsm == RUN);
endmodule
